// File: rtl/dtcore32_lsu.sv
// dtcore32_lsu: memory-stage load/store unit driving a single-outstanding req/gnt data bus.
// Define DTCORE32_LSU_MISALIGN_TRAP_EN to trap misaligned accesses without issuing them to the bus.
module dtcore32_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic [4:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_rdata_o,
    output logic        trap_valid_o,
    output logic [31:0] trap_mcause_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] op_q;
    logic [1:0] lo_q;
    logic [CW-1:0] cnt_q;
    logic drop_q, accept, misal, timeout, st, ok;
    logic [3:0] strb;
    logic [31:0] wdata, fmt;
    logic [15:0] lane_h;
    logic [7:0] lane_b;
    // mem_op: [4] access, [3] store, [2] unsigned, [1:0] size (0 byte, 1 half, 2 word)
    assign accept = state_q == IDLE && req_valid_i && mem_op_i[4];
`ifdef DTCORE32_LSU_MISALIGN_TRAP_EN
    assign misal = (mem_op_i[1:0] == 2'b01 && addr_i[0]) || (mem_op_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif
    assign timeout = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
    assign st = state_q == IDLE ? mem_op_i[3] : op_q[3];
    assign ok = state_q == RSP && bus_rvalid_i && !bus_err_i;
    assign strb = !mem_op_i[3] ? 4'b0000 : mem_op_i[1] ? 4'b1111 :
                  mem_op_i[0] ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_i[1:0];
    assign wdata = !mem_op_i[3] ? 32'd0 : mem_op_i[1] ? store_wdata_i :
                   mem_op_i[0] ? {2{store_wdata_i[15:0]}} : {4{store_wdata_i[7:0]}};
    assign lane_b = bus_rdata_i[{lo_q, 3'b000} +: 8];
    assign lane_h = lo_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    assign fmt = op_q[1] ? bus_rdata_i : op_q[0] ? {{16{!op_q[2] && lane_h[15]}}, lane_h} :
                 {{24{!op_q[2] && lane_b[7]}}, lane_b};
    assign stall_o = accept || state_q == REQ || state_q == RSP;
    assign done_o = state_q == DONE;
    assign bus_req_o = state_q == REQ;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = misal ? DONE : REQ;
            REQ:
                if (flush_i) state_d = bus_gnt_i ? RSP : IDLE;
                else if (timeout) state_d = DONE;
                else if (bus_gnt_i) state_d = RSP;
            RSP: if (bus_rvalid_i || timeout) state_d = (drop_q || flush_i) ? IDLE : DONE;
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            lo_q <= '0;
            cnt_q <= '0;
            drop_q <= 1'b0;
            bus_we_o <= 1'b0;
            bus_addr_o <= '0;
            bus_wstrb_o <= '0;
            bus_wdata_o <= '0;
            load_rdata_o <= '0;
            trap_valid_o <= 1'b0;
            trap_mcause_o <= '0;
        end else begin
            if (accept) begin
                op_q <= mem_op_i[3:0];
                lo_q <= addr_i[1:0];
                bus_we_o <= mem_op_i[3];
                bus_addr_o <= {addr_i[31:2], 2'b00};
                bus_wstrb_o <= strb;
                bus_wdata_o <= wdata;
            end
            cnt_q <= accept ? '0 : (state_q == REQ || state_q == RSP) ? cnt_q + 1'b1 : cnt_q;
            if (accept) drop_q <= 1'b0;
            else if (flush_i && (state_q == RSP || (state_q == REQ && bus_gnt_i))) drop_q <= 1'b1;
            // codes: 4/6 misaligned load/store, 5/7 load/store access fault
            if (state_d == DONE) begin
                load_rdata_o <= ok && !st ? fmt : 32'd0;
                trap_valid_o <= !ok;
                trap_mcause_o <= ok ? 32'd0 : {29'd0, 1'b1, st, state_q != IDLE};
            end
        end
    end
endmodule

// File: tb/tb_dtcore32_lsu.sv
// tb_dtcore32_lsu: scoreboard bench for dtcore32_lsu with a scripted bus responder.
module tb_dtcore32_lsu;
    localparam logic [4:0] LB = 5'b10000, LH = 5'b10001, LW = 5'b10010, LBU = 5'b10100;
    localparam logic [4:0] LHU = 5'b10101, SB = 5'b11000, SH = 5'b11001, SW = 5'b11010;
    typedef struct packed {
        logic [31:0] data;
        logic        trap;
        logic [31:0] cause;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid_i = 1'b0, flush_i = 1'b0;
    logic [4:0] mem_op_i = '0;
    logic [31:0] addr_i = '0, store_wdata_i = '0, bus_rdata_i = '0;
    logic bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
    logic stall_o, done_o, trap_valid_o, bus_req_o, bus_we_o;
    logic [31:0] load_rdata_o, trap_mcause_o, bus_addr_o, bus_wdata_o;
    logic [3:0] bus_wstrb_o;
    exp_t sb[$];
    int n_vec = 0, n_err = 0;
    int dc, st;

    dtcore32_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .mem_op_i(mem_op_i),
        .addr_i(addr_i), .store_wdata_i(store_wdata_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .load_rdata_o(load_rdata_o),
        .trap_valid_o(trap_valid_o), .trap_mcause_o(trap_mcause_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("load_rdata", load_rdata_o, e.data);
                check("trap_valid", 32'(trap_valid_o), 32'(e.trap));
                check("trap_mcause", trap_mcause_o, e.cause);
            end
        end
    end

    // One access: accept cycle is cycle 0; done_cyc is the cycle index of done_o (-1 if none).
    task automatic access(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_dly, input int rsp_dly, input logic [31:0] rd,
                          input logic err, input bit respond, input int flush_at,
                          input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, output int done_cyc, output int stalls);
        int nreq, nrsp;
        bit fin;
        nreq = 0; nrsp = 0; fin = 0; done_cyc = -1; stalls = 0;
        req_valid_i = 1'b1; mem_op_i = op; addr_i = a; store_wdata_i = wd;
        @(negedge clk);
        stalls += int'(stall_o);
        @(posedge clk); #1;
        req_valid_i = 1'b0; mem_op_i = '0; addr_i = '0; store_wdata_i = '0;
        for (int c = 1; c < 40 && !fin; c++) begin
            if (done_o) begin
                done_cyc = c;
                fin = 1;
            end else if (bus_req_o) begin
                check("bus_addr", bus_addr_o, e_addr);
                check("bus_we", 32'(bus_we_o), 32'(e_we));
                check("bus_wstrb", 32'(bus_wstrb_o), 32'(e_strb));
                check("bus_wdata", bus_wdata_o, e_wdata);
                bus_gnt_i = nreq == gnt_dly;
                nreq++;
            end else if (stall_o) begin
                bus_rvalid_i = respond && nrsp == rsp_dly;
                bus_err_i = err && bus_rvalid_i;
                bus_rdata_i = rd;
                nrsp++;
            end else fin = 1;
            flush_i = c == flush_at;
            @(negedge clk);
            stalls += int'(stall_o);
            @(posedge clk); #1;
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; flush_i = 1'b0;
        end
        if (!fin) check("access_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_bus", {bus_addr_o[27:0], bus_wstrb_o} | bus_wdata_o | 32'(bus_we_o), 32'd0);
        check("rst_result", load_rdata_o | trap_mcause_o | 32'(trap_valid_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        sb.push_back({32'hFFFF_FF80, 1'b0, 32'd0});
        access(LB, 32'h103, 32'h0, 0, 0, 32'h80FF_FF12, 1'b0, 1, -1, 32'h100, 1'b0, 4'b0000, 32'h0, dc, st);
        check("lb_done_cycle", 32'(dc), 32'd3);
        check("lb_stall_cycles", 32'(st), 32'd3);

        sb.push_back({32'h0, 1'b0, 32'd0});
        access(SH, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0, 1, -1, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, dc, st);
        check("sh_done_cycle", 32'(dc), 32'd3);

        sb.push_back({32'h0000_8001, 1'b0, 32'd0});
        access(LHU, 32'h0, 32'h0, 5, 0, 32'h0000_8001, 1'b0, 1, -1, 32'h0, 1'b0, 4'b0000, 32'h0, dc, st);
        check("lhu_done_cycle", 32'(dc), 32'd8);

        sb.push_back({32'hFFFF_8001, 1'b0, 32'd0});
        access(LH, 32'h2, 32'h0, 0, 2, 32'h8001_1234, 1'b0, 1, -1, 32'h0, 1'b0, 4'b0000, 32'h0, dc, st);
        check("lh_done_cycle", 32'(dc), 32'd5);

        sb.push_back({32'h0000_00F2, 1'b0, 32'd0});
        access(LBU, 32'h1, 32'h0, 1, 0, 32'h0000_F200, 1'b0, 1, -1, 32'h0, 1'b0, 4'b0000, 32'h0, dc, st);

        sb.push_back({32'h0, 1'b0, 32'd0});
        access(SB, 32'h3, 32'h0000_0055, 0, 0, 32'h0, 1'b0, 1, -1, 32'h0, 1'b1, 4'b1000, 32'h5555_5555, dc, st);

        sb.push_back({32'h0, 1'b0, 32'd0});
        access(SW, 32'h10, 32'hCAFE_F00D, 0, 1, 32'h0, 1'b0, 1, -1, 32'h10, 1'b1, 4'b1111, 32'hCAFE_F00D, dc, st);

        sb.push_back({32'h0, 1'b1, 32'd5});
        access(LW, 32'h20, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1, -1, 32'h20, 1'b0, 4'b0000, 32'h0, dc, st);

        sb.push_back({32'h0, 1'b1, 32'd7});
        access(SB, 32'h21, 32'h0000_00A5, 0, 0, 32'h0, 1'b1, 1, -1, 32'h20, 1'b1, 4'b0010, 32'hA5A5_A5A5, dc, st);

        sb.push_back({32'h0, 1'b1, 32'd7});
        access(SW, 32'h30, 32'h1111_2222, 1000, 0, 32'h0, 1'b0, 0, -1, 32'h30, 1'b1, 4'b1111, 32'h1111_2222, dc, st);
        check("sw_timeout_cycle", 32'(dc), 32'd9);
        check("sw_timeout_stalls", 32'(st), 32'd9);

        sb.push_back({32'h0, 1'b1, 32'd5});
        access(LW, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0, 0, -1, 32'h40, 1'b0, 4'b0000, 32'h0, dc, st);
        check("lw_timeout_cycle", 32'(dc), 32'd9);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        @(negedge clk);
        check("late_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check("late_done", 32'(done_o), 32'd0);
        check("late_rdata", load_rdata_o, 32'h0);
        @(posedge clk); #1;

        access(LW, 32'h50, 32'h0, 0, 2, 32'h5555_AAAA, 1'b0, 1, 2, 32'h50, 1'b0, 4'b0000, 32'h0, dc, st);
        check("flush_rsp_no_done", 32'(dc), 32'hFFFF_FFFF);
        access(LW, 32'h60, 32'h0, 0, 1, 32'h6666_0000, 1'b0, 1, 1, 32'h60, 1'b0, 4'b0000, 32'h0, dc, st);
        check("flush_gnt_no_done", 32'(dc), 32'hFFFF_FFFF);
        access(LW, 32'h70, 32'h0, 3, 0, 32'h7777_0000, 1'b0, 1, 1, 32'h70, 1'b0, 4'b0000, 32'h0, dc, st);
        check("flush_req_no_done", 32'(dc), 32'hFFFF_FFFF);
        check("flush_req_stalls", 32'(st), 32'd2);

        sb.push_back({32'h0000_007F, 1'b0, 32'd0});
        access(LB, 32'h0, 32'h0, 0, 0, 32'hFFFF_FF7F, 1'b0, 1, -1, 32'h0, 1'b0, 4'b0000, 32'h0, dc, st);
        check("post_flush_done_cycle", 32'(dc), 32'd3);

`ifdef DTCORE32_LSU_MISALIGN_TRAP_EN
        sb.push_back({32'h0, 1'b1, 32'd4});
        access(LW, 32'h102, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1, -1, 32'h100, 1'b0, 4'b0000, 32'h0, dc, st);
        check("misal_done_cycle", 32'(dc), 32'd1);
`else
        sb.push_back({32'hDEAD_BEEF, 1'b0, 32'd0});
        access(LW, 32'h102, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1, -1, 32'h100, 1'b0, 4'b0000, 32'h0, dc, st);
        check("misal_done_cycle", 32'(dc), 32'd3);
`endif

        req_valid_i = 1'b1; mem_op_i = SW; addr_i = 32'h84; store_wdata_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req_valid_i = 1'b0; mem_op_i = '0;
        check("midrst_req_before", 32'(bus_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(bus_req_o), 32'd0);
        check("midrst_stall", 32'(stall_o), 32'd0);
        check("midrst_bus", bus_addr_o | bus_wdata_o | 32'(bus_wstrb_o) | 32'(bus_we_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
